spi_master_burst: RTL
=====================

Name: spi_master_burst

Overview:
Parametrised SPI master, the next generation of the team's single-byte SPI master. It adds configurable word width and frame length, multiple chip selects, and a programmable integer clock divider. It supports burst transfers with chip-select held between words and uses valid/ready handshakes on TX. It sits on the peripheral bus between the CPU register interface and external SPI devices. All SPI outputs are registered, and there is no clock pass-through.

Parameters:
DATA_W, 8, maximum word width in bits (>=2)
NUM_CS, 4, number of chip-select lines (>=2)
DIV_W, 8, width of clock divider field
CS_W (localparam), $clog2(NUM_CS), chip-select index width
LEN_W (localparam), $clog2(DATA_W), frame-length field width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cfg_cpol  in  1  SCLK idle level
cfg_cpha  in  1  0: sample on leading edge; 1: sample on trailing edge
cfg_lsb_first  in  1  1: LSB transmitted/received first
cfg_div  in  DIV_W  SCLK half-period = cfg_div+1 clk cycles
cfg_len_m1  in  LEN_W  bits per word minus one
cfg_cs_sel  in  CS_W  index of chip select to drive
tx_valid  in  1  tx word offered
tx_ready  out  1  master accepts word this cycle
tx_data  in  DATA_W  word to send, bits [len-1:0] significant
tx_last  in  1  deassert CS after this word
rx_valid  out  1  one-cycle pulse, rx_data valid
rx_data  out  DATA_W  received word, LSB-aligned, upper bits zero
busy  out  1  high whenever state != IDLE
spi_clk  out  1  SPI clock
spi_mosi  out  1  master out
spi_miso  in  1  master in
spi_cs_n  out  NUM_CS  active-low chip selects, one-hot-low when active

Behaviour:
- Reset (async, rst_n=0): state IDLE, spi_cs_n all 1, spi_clk 0, spi_mosi 0, rx_data 0, rx_valid 0, tx_ready 0, busy 0. Reset mid-frame aborts immediately. No rx_valid is produced. CS releases in the same instant.
- Config (cpol, cpha, lsb_first, div, len_m1, cs_sel) is latched on the accept handshake in IDLE. It is held for the whole burst. Changes mid-burst are ignored until the next IDLE accept.
- In IDLE, spi_clk tracks cfg_cpol (registered, 1-cycle lag) and tx_ready=1.
- Half-period tick: a DIV_W counter reloads at cfg_div and ticks when it reaches 0.
- FSM states:
  - IDLE: on tx_valid&tx_ready, capture data/last/config; go to SETUP.
  - SETUP: assert spi_cs_n[cs_sel]=0. If cpha=0, drive the first bit on MOSI. Wait one half-period, then go to SHIFT.
  - SHIFT: toggle spi_clk on each tick, 2*(len) edges per word.
    - cpha=0: sample MISO on odd edges, shift MOSI on even edges except the last.
    - cpha=1: drive MOSI on odd edges, sample on even edges.
    - After the final edge, spi_clk is back at cpol and rx_valid pulses for 1 cycle with rx_data.
    - Then go to HOLD if last=1, else WAIT.
  - WAIT: CS stays asserted, spi_clk=cpol, tx_ready=1.
    - Accept next word (data/last only; config retained).
    - Go to SETUP-equivalent one half-period gap, then SHIFT.
    - Stays in WAIT indefinitely without tx_valid.
  - HOLD: keep CS one half-period after the final edge, then deassert CS. Go to GAP.
  - GAP: CS high one half-period (minimum deselect time), then IDLE.
- Bit order:
  - MSB-first sends tx_data[len-1] first. LSB-first sends tx_data[0] first.
  - Received bits assemble so rx_data[len-1:0] matches that same significance.
  - rx_data[DATA_W-1:len] = 0.
- Frame length 1 (len_m1=0) is legal: 2 edges.
- tx_ready is 0 in SETUP/SHIFT/HOLD/GAP. The handshake completes only when both tx_valid and tx_ready are high in the same cycle.
- rx_valid and a new accept in WAIT cannot coincide; rx_valid precedes WAIT by one cycle.
- Word duration at div=d: setup (d+1) + 2*len*(d+1) cycles.

Decomposition:
- Shared package spi_pkg: state enum (IDLE, SETUP, SHIFT, WAIT, HOLD, GAP) and mode constants (MODE0..MODE3 as {cpol,cpha}).
- One sub-module, spi_clk_gen: divider counter, tick output, spi_clk toggle/idle-level register.
- Shift/FSM logic stays in the top.

Test Plan:
- Mode 0, div=0, len_m1=7, cs_sel=0, tx 0xA5, last=1, MISO looped to MOSI:
  - CS0 low, 8 rising edges.
  - MOSI 1,0,1,0,0,1,0,1.
  - rx_valid once with rx_data=0xA5.
  - CS0 high; busy low after GAP.
- Mode 3, lsb_first=1, div=3, tx 0x01, MISO tied 1:
  - SCLK idles high, half-period 4 clk.
  - First MOSI bit 1.
  - rx_data=0xFF.
- Burst of 3 words 0x11, 0x22, 0x33 (last on third), cs_sel=2:
  - spi_cs_n=4'b1011 continuously across all words.
  - 3 rx_valid pulses.
  - Config change after word 1 has no effect.
- len_m1=4, tx 0xFF, loopback:
  - 5 clock pulses.
  - rx_data=0x1F.
- Reset asserted mid-SHIFT of word 2 in a burst:
  - spi_cs_n immediately 4'hF, spi_clk 0, no rx_valid.
  - Next transfer after release completes normally.
- WAIT stall, tx_valid withheld 50 cycles:
  - CS held low, spi_clk=cpol, tx_ready=1 throughout.
  - Then word accepted and transferred.

Source files
------------

// File: rtl/spi_master_burst_pkg.sv
// Shared definitions for the burst SPI master: FSM state codes,
// SPI mode constants and the latched mode record.
package spi_pkg;

    // FSM state encoding
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;

    // SPI modes as {cpol, cpha}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    // Per-burst mode flags captured on the IDLE accept
    typedef struct packed {
        logic cpol;
        logic cpha;
        logic lsb_first;
    } spi_mode_t;

endpackage

// File: rtl/spi_master_burst_if.sv
// Word-level bus between the register block and the SPI master:
// TX valid/ready handshake plus the RX result pulse.
interface spi_master_burst_if #(
    parameter int DATA_W = 8
);
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] tx_data;
    logic              tx_last;
    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;

    // Word source (CPU side)
    modport master (
        output tx_valid, tx_data, tx_last,
        input  tx_ready, rx_valid, rx_data
    );

    // SPI master side
    modport slave (
        input  tx_valid, tx_data, tx_last,
        output tx_ready, rx_valid, rx_data
    );
endinterface

// File: rtl/spi_master_burst_clk_gen.sv
// Half-period divider and SCLK register. The counter reloads from div
// whenever it is disabled or has just ticked, so every enabled phase
// lasts exactly div+1 cycles.
module spi_clk_gen #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    input  logic             load_idle,
    input  logic             idle_level,
    input  logic             toggle,
    output logic             tick,
    output logic             spi_clk
);
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             sclk_q, sclk_d;

    assign tick    = en && (cnt_q == '0);
    assign spi_clk = sclk_q;

    // Next divider count: reload when idle or on tick, else count down
    always_comb begin
        cnt_d = cnt_q;
        if (!en || tick) begin
            cnt_d = div;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Next SCLK level: forced to the idle level, or toggled on a shift edge
    always_comb begin
        sclk_d = sclk_q;
        if (load_idle) begin
            sclk_d = idle_level;
        end else if (toggle) begin
            sclk_d = ~sclk_q;
        end
    end

    // Divider and SCLK state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end
endmodule

// File: rtl/spi_master_burst.sv
// Burst-capable SPI master: variable word length, selectable chip select,
// integer SCLK divider, CS held between words until tx_last.
module spi_master_burst
    import spi_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int NUM_CS = 4,
    parameter  int DIV_W  = 8,
    localparam int CS_W   = $clog2(NUM_CS),
    localparam int LEN_W  = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_cpol,
    input  logic              cfg_cpha,
    input  logic              cfg_lsb_first,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [LEN_W-1:0]  cfg_len_m1,
    input  logic [CS_W-1:0]   cfg_cs_sel,
    spi_master_burst_if.slave bus,
    output logic              busy,
    output logic              spi_clk,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic [NUM_CS-1:0] spi_cs_n
);
    localparam logic [NUM_CS-1:0] CS_ONE = {{(NUM_CS-1){1'b0}}, 1'b1};

    logic [2:0]        state_q, state_d;
    spi_mode_t         mode_q, mode_d;
    logic [LEN_W-1:0]  len_m1_q, len_m1_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              last_q, last_d;
    logic [DATA_W-1:0] tx_word_q, tx_word_d;
    logic [DATA_W-1:0] rx_word_q, rx_word_d;
    logic [LEN_W-1:0]  bit_k_q, bit_k_d;
    logic [LEN_W:0]    edge_cnt_q, edge_cnt_d;
    logic              done_q, done_d;
    logic              rx_valid_q, rx_valid_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              tx_ready_q, tx_ready_d;
    logic [NUM_CS-1:0] cs_n_q, cs_n_d;
    logic              mosi_q, mosi_d;

    logic              accept;
    logic              tick;
    logic              div_en;
    logic              final_edge;
    logic [LEN_W-1:0]  bit_nx;
    logic              eff_cpha;
    logic              eff_lsb;
    logic [LEN_W-1:0]  eff_len_m1;
    logic [DIV_W-1:0]  div_sel;

    // Position inside the word of the k-th transferred bit
    function automatic logic [LEN_W-1:0] bit_pos(input logic [LEN_W-1:0] k,
                                                 input logic [LEN_W-1:0] len_m1,
                                                 input logic             lsb);
        return lsb ? k : (len_m1 - k);
    endfunction

    // In IDLE the live config applies (it is being captured); afterwards the latched copy
    assign eff_cpha   = (state_q == S_IDLE) ? cfg_cpha      : mode_q.cpha;
    assign eff_lsb    = (state_q == S_IDLE) ? cfg_lsb_first : mode_q.lsb_first;
    assign eff_len_m1 = (state_q == S_IDLE) ? cfg_len_m1    : len_m1_q;
    assign div_sel    = (state_q == S_IDLE) ? cfg_div       : div_q;

    assign accept     = bus.tx_valid && tx_ready_q;
    assign final_edge = (edge_cnt_q == {len_m1_q, 1'b1});
    assign bit_nx     = bit_k_q + 1'b1;
    // The cycle after the final edge (done_q) is not timed, so the divider reloads there
    assign div_en     = (state_q == S_SETUP) || (state_q == S_HOLD) || (state_q == S_GAP)
                     || ((state_q == S_SHIFT) && !done_q);

    spi_clk_gen #(
        .DIV_W (DIV_W)
    ) u_clk_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (div_en),
        .div        (div_sel),
        .load_idle  ((state_q != S_SETUP) && (state_q != S_SHIFT)),
        .idle_level ((state_q == S_IDLE) ? cfg_cpol : mode_q.cpol),
        .toggle     ((state_q == S_SHIFT) && tick),
        .tick       (tick),
        .spi_clk    (spi_clk)
    );

    // FSM, shift registers and registered SPI/bus outputs
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        len_m1_d   = len_m1_q;
        div_d      = div_q;
        last_d     = last_q;
        tx_word_d  = tx_word_q;
        rx_word_d  = rx_word_q;
        bit_k_d    = bit_k_q;
        edge_cnt_d = edge_cnt_q;
        done_d     = done_q;
        rx_valid_d = 1'b0;
        rx_data_d  = rx_data_q;
        cs_n_d     = cs_n_q;
        mosi_d     = mosi_q;

        case (state_q)
            S_IDLE, S_WAIT: begin
                if (accept) begin
                    if (state_q == S_IDLE) begin
                        mode_d.cpol      = cfg_cpol;
                        mode_d.cpha      = cfg_cpha;
                        mode_d.lsb_first = cfg_lsb_first;
                        len_m1_d         = cfg_len_m1;
                        div_d            = cfg_div;
                        cs_n_d           = ~(CS_ONE << cfg_cs_sel);
                    end
                    tx_word_d = bus.tx_data;
                    last_d    = bus.tx_last;
                    rx_word_d = '0;
                    bit_k_d   = '0;
                    // cpha=0 slaves sample on the first edge, so bit 0 must already be on MOSI
                    if (!eff_cpha) begin
                        mosi_d = bus.tx_data[bit_pos('0, eff_len_m1, eff_lsb)];
                    end
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (tick) begin
                    edge_cnt_d = '0;
                    state_d    = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (done_q) begin
                    // rx_valid is high this cycle; the next state may accept a word
                    done_d  = 1'b0;
                    state_d = last_q ? S_HOLD : S_WAIT;
                end else if (tick) begin
                    edge_cnt_d = edge_cnt_q + 1'b1;
                    if (!edge_cnt_q[0]) begin
                        // odd (leading) edge
                        if (!mode_q.cpha) begin
                            rx_word_d[bit_pos(bit_k_q, len_m1_q, mode_q.lsb_first)] = spi_miso;
                        end else begin
                            mosi_d = tx_word_q[bit_pos(bit_k_q, len_m1_q, mode_q.lsb_first)];
                        end
                    end else begin
                        // even (trailing) edge
                        if (mode_q.cpha) begin
                            rx_word_d[bit_pos(bit_k_q, len_m1_q, mode_q.lsb_first)] = spi_miso;
                            bit_k_d = bit_nx;
                        end else if (!final_edge) begin
                            bit_k_d = bit_nx;
                            mosi_d  = tx_word_q[bit_pos(bit_nx, len_m1_q, mode_q.lsb_first)];
                        end
                    end
                    if (final_edge) begin
                        done_d     = 1'b1;
                        rx_valid_d = 1'b1;
                        rx_data_d  = rx_word_d;
                    end
                end
            end
            S_HOLD: begin
                if (tick) begin
                    cs_n_d  = '1;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (tick) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                cs_n_d  = '1;
                state_d = S_IDLE;
            end
        endcase

        tx_ready_d = (state_d == S_IDLE) || (state_d == S_WAIT);
    end

    // State and output registers; reset aborts any frame and releases CS at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            mode_q     <= '0;
            len_m1_q   <= '0;
            div_q      <= '0;
            last_q     <= 1'b0;
            tx_word_q  <= '0;
            rx_word_q  <= '0;
            bit_k_q    <= '0;
            edge_cnt_q <= '0;
            done_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            tx_ready_q <= 1'b0;
            cs_n_q     <= '1;
            mosi_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            len_m1_q   <= len_m1_d;
            div_q      <= div_d;
            last_q     <= last_d;
            tx_word_q  <= tx_word_d;
            rx_word_q  <= rx_word_d;
            bit_k_q    <= bit_k_d;
            edge_cnt_q <= edge_cnt_d;
            done_q     <= done_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            tx_ready_q <= tx_ready_d;
            cs_n_q     <= cs_n_d;
            mosi_q     <= mosi_d;
        end
    end

    assign bus.tx_ready = tx_ready_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.rx_data  = rx_data_q;
    assign busy         = (state_q != S_IDLE);
    assign spi_mosi     = mosi_q;
    assign spi_cs_n     = cs_n_q;
endmodule
